lc3_intc: RTL

Parametrised interrupt controller for the LC-3 core. It collects NUM_CH device request lines and arbitrates among them by per-channel priority. It drives the core's IRQ/INTV/INTP inputs and holds them stable until the core acknowledges. It sits between the memory-mapped device models and the lc3 core, replacing the single hard-wired request source with a scalable, priority-ordered one.

---
 rtl/lc3_intc.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lc3_intc.sv
// Priority interrupt controller for the LC-3 core: captures NUM_CH request lines,
// picks the highest-priority eligible channel and presents it on IRQ/INTV/INTP until acked.
// Optional feature: define LC3_INTC_EDGE_EN for sticky edge-triggered pending bits (default: level mode).
module lc3_intc #(
  parameter int         NUM_CH   = 4,
  parameter logic [7:0] VEC_BASE = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [3*NUM_CH-1:0]   ch_pri,
  input  logic [2:0]            cpu_pri,
  input  logic                  intack,
  output logic                  IRQ,
  output logic [7:0]            INTV,
  output logic [2:0]            INTP,
  output logic [NUM_CH-1:0]     pending_o
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_ACK  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] w_elig;
  logic [2:0]        w_pri [NUM_CH];
  logic [IW-1:0]     r_win;
  logic [IW-1:0]     w_win;
  logic [2:0]        r_pri;
  logic [2:0]        w_best_pri;
  logic [7:0]        r_vec;
  logic              w_any;
  logic              w_win_ok;
  logic              w_take;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_pri[g]  = ch_pri[3*g +: 3];
    assign w_elig[g] = r_pend[g] & ch_en[g] & (w_pri[g] > cpu_pri);
  end

  // Strict '>' keeps the lowest index on priority ties.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_best_pri = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_elig[i] && (!w_any || (w_pri[i] > w_best_pri))) begin
        w_any      = 1'b1;
        w_win      = IW'(i);
        w_best_pri = w_pri[i];
      end
    end
  end

  // The presented request stays valid only while its channel could still win on its own.
  assign w_win_ok = r_pend[r_win] & ch_en[r_win] & (r_pri > cpu_pri);
  assign w_take   = (r_state == S_IDLE) & w_any;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_REQ;
      S_REQ: begin
        if (intack)         w_state_nxt = S_ACK;
        else if (!w_win_ok) w_state_nxt = S_IDLE;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    IRQ       = (r_state == S_REQ);
    INTV      = r_vec;
    INTP      = r_pri;
    pending_o = r_pend;
  end

  // Vector and priority freeze at the IDLE->REQ transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win <= '0;
      r_vec <= 8'h00;
      r_pri <= 3'b000;
    end else if (w_take) begin
      r_win <= w_win;
      r_vec <= VEC_BASE + 8'(w_win);
      r_pri <= w_best_pri;
    end
  end

`ifdef LC3_INTC_EDGE_EN
  logic [NUM_CH-1:0] r_req_d;
  logic [NUM_CH-1:0] w_clr;
  logic              w_ack;

  assign w_ack = (r_state == S_REQ) & intack;

  always_comb begin
    w_clr = '0;
    if (w_ack) w_clr[r_win] = 1'b1;
  end

  // A new rising edge in the ack cycle re-arms the channel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_d <= '0;
      r_pend  <= '0;
    end else begin
      r_req_d <= req;
      r_pend  <= (r_pend & ~w_clr) | (req & ~r_req_d);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= req;
  end
`endif

endmodule
